// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: N-channel arbiter with fixed-priority or round-robin
// selection. A grant is held until the grantee pulses done. On that release
// the block re-arbitrates in the same cycle, so back-to-back grants leave no
// idle gap.
//
// Ports:
//   clk  - clock, rising-edge active
//   rst  - asynchronous active-high reset
//   d    - request vector, d[i]=1 when channel i requests
//   mode - 0: fixed priority (highest index wins), 1: round-robin
//   en   - arbitration enable; gates issuing of new grants
//   done - one-cycle release pulse from the current grantee
//   y    - registered index of the granted channel
//   v    - registered grant-valid flag
//   ptr  - registered round-robin pointer (last granted channel)
module rr_priority_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         mode,
  input  logic         en,
  input  logic         done,
  output logic [W-1:0] y,
  output logic         v,
  output logic [W-1:0] ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] req;
  logic [W-1:0] win;
  logic         found;
  int           idx;

  // Winner selection. While granted, the current grantee's own bit is
  // masked so a release cannot hand the grant straight back to it.
  always_comb begin
    req   = d;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (state == GRANT) begin
      req[y] = 1'b0;
    end
    if (!mode) begin
      // Ascending scan; the last hit is the highest set index.
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) begin
          win   = W'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Descend from ptr-1 with wrap, so channel ptr is visited last.
      for (int k = 1; k <= int'(N); k++) begin
        idx = int'(ptr) - k;
        if (idx < 0) begin
          idx = idx + int'(N);
        end
        if (!found && req[idx]) begin
          win   = W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // State, grant index, valid flag and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      v     <= 1'b0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            state <= GRANT;
            y     <= win;
            v     <= 1'b1;
            ptr   <= win;
          end
        end
        GRANT: begin
          if (done) begin
            if (en && found) begin
              y   <= win;
              ptr <= win;
            end else begin
              state <= IDLE;
              v     <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          v     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_priority_arbiter.md
RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 Parameter: N, default 8, number of request channels (legal range 2..32).
REQ-002 Parameter: W, default $clog2(N), width of the grant index.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: d  input  N  request vector; d[i]=1 means channel i requests.
REQ-006 Port: mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 Port: en  input  1  arbitration enable; new grants are issued only when en=1.
REQ-008 Port: done  input  1  one-cycle release pulse from the current grantee.
REQ-009 Port: y  output  W  registered index of the granted channel.
REQ-010 Port: v  output  1  registered grant-valid flag; y is meaningful only when v=1.
REQ-011 Port: ptr  output  W  registered round-robin pointer, exposed for debug and verification.

Function
REQ-012 The block SHALL implement two states: IDLE (v=0) and GRANT (v=1).
REQ-013 In IDLE with en=1 and |d=1, the block SHALL select a winner combinationally, register it into y, and set v=1 on the next rising edge (latency 1 cycle).
REQ-014 In IDLE with en=0 or d=0, the block SHALL stay in IDLE and hold y unchanged.
REQ-015 With mode=0, the winner SHALL be the highest set index of d (d[N-1] highest priority).
REQ-016 With mode=1, the search SHALL start at index ptr-1 and descend, wrapping from 0 to N-1; the first set bit wins, and channel ptr is checked last.
REQ-017 On every issued grant to channel k, in either mode, ptr SHALL be loaded with k.
REQ-018 In GRANT, y and v SHALL hold constant regardless of changes on d, mode or en until done=1.
REQ-019 In GRANT with done=1, the block SHALL re-arbitrate in the same cycle using the current d, mode and en, with the granted channel's own request bit masked, so there is no idle gap.
REQ-020 If that re-arbitration finds no winner, or en=0, the block SHALL go to IDLE with v=0 on the next edge.
REQ-021 A done pulse in IDLE SHALL be ignored.
REQ-022 A mode change SHALL take effect only at the next arbitration point; it SHALL NOT alter a grant in progress.
REQ-023 Arithmetic on ptr SHALL wrap modulo N; for non-power-of-two N, indices >= N SHALL never be produced.
REQ-024 A grantee dropping its request while in GRANT without pulsing done SHALL keep the grant; release is by done only.

Reset
REQ-025 When rst is asserted, the block SHALL asynchronously force state=IDLE, y=0, v=0 and ptr=0, independent of clk.
REQ-026 When rst is asserted mid-grant, the block SHALL drop the grant immediately (v=0 without waiting for an edge).
REQ-027 After rst deasserts, arbitration SHALL resume on the first rising edge with en=1 and |d=1.

Verification (bench at N=4)
REQ-028 Fixed priority: mode=0, en=1, d=4'b1010 -> y=3, v=1 one cycle later; done pulse with d=4'b0010 -> y=1 on the next edge with no v=0 cycle.
REQ-029 Priority walk: mode=0, d stepped through 0000, 1000, 0100, 0010, 0001 with a done pulse after each grant -> v=0, then y=3, 2, 1, 0 in turn.
REQ-030 Round-robin fairness: mode=1, d=4'b1111 held, done pulsed every cycle -> y sequence 3, 2, 1, 0, 3 and ptr tracks y.
REQ-031 Hold: in GRANT with y=2, d changed to 1000 and mode toggled without done -> y stays 2 and v stays 1 for 10 cycles.
REQ-032 Reset: rst asserted between clock edges while v=1 -> v=0, y=0, ptr=0 immediately; after release with en=1 and d=0001 -> y=0, v=1 one cycle later.
REQ-033 Enable and empty: en=0 with d=1111 -> v stays 0; a done pulse in IDLE -> no change; a done pulse in GRANT with d reduced to only the grantee's bit -> v=0 on the next edge.
